// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pkg : register-file geometry shared by write-back/issue logic  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package mips_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NREG   = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_rr_arbiter : one-hot grant searching upward from ptr (mod N);    |
// |                 ptr=0 gives plain lowest-index-first priority.      |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  import mips_pkg::*;

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/wb_port_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_port_scheduler : shares the RF write port among NREQ requesters  |
// |   and keeps the destination busy scoreboard. WB_RR_EN selects       |
// |   round-robin arbitration, otherwise fixed lowest-index priority.   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_port_scheduler #(
  parameter int NREQ   = 3,
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int REG_DW = mips_pkg::REG_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*REG_AW-1:0]   req_addr,
  input  logic [NREQ*REG_DW-1:0]   req_data,
  input  logic                     rsv_valid,
  input  logic [REG_AW-1:0]        rsv_addr,
  output logic                     rsv_busy,
  input  logic [REG_AW-1:0]        rd1_addr,
  input  logic [REG_AW-1:0]        rd2_addr,
  output logic                     rd1_busy,
  output logic                     rd2_busy,
  output logic                     Regwf,
  output logic [REG_AW-1:0]        Regwadd,
  output logic [REG_DW-1:0]        Regwdata
);
  import mips_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     rr_ptr;
  logic              any;
  logic              xfer;
  logic [REG_AW-1:0] gaddr;
  logic [REG_DW-1:0] gdata;
  logic [NREG-1:0]   busy;

  wb_rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  // Reset masks the grant so nothing is accepted while rst is high.
  assign req_ready = grant & {NREQ{~rst}};
  assign xfer      = any & ~rst;
  assign gaddr     = req_addr[int'(gidx)*REG_AW +: REG_AW];
  assign gdata     = req_data[int'(gidx)*REG_DW +: REG_DW];

`ifdef WB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // $zero writes are accepted and silently dropped at the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      Regwf    <= 1'b0;
      Regwadd  <= '0;
      Regwdata <= '0;
    end else if (xfer) begin
      Regwf    <= (gaddr != REG_ZERO);
      Regwadd  <= gaddr;
      Regwdata <= gdata;
    end else begin
      Regwf    <= 1'b0;
    end
  end

  // Set is ordered after clear so a same-edge reserve of the retiring register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (Regwf) busy[Regwadd] <= 1'b0;
      if (rsv_valid && (rsv_addr != REG_ZERO)) busy[rsv_addr] <= 1'b1;
    end
  end

  assign rsv_busy = (rsv_addr != REG_ZERO) & busy[rsv_addr];
  assign rd1_busy = (rd1_addr != REG_ZERO) & busy[rd1_addr];
  assign rd2_busy = (rd2_addr != REG_ZERO) & busy[rd2_addr];
endmodule
`default_nettype wire

// File: tb/tb_wb_port_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_port_scheduler : directed scenarios plus randomized traffic   |
// |   against a behavioural model of arbitration and the scoreboard.    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_wb_port_scheduler;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_busy;
  logic [AW-1:0]        rd1_addr;
  logic [AW-1:0]        rd2_addr;
  logic                 rd1_busy;
  logic                 rd2_busy;
  logic                 Regwf;
  logic [AW-1:0]        Regwadd;
  logic [DW-1:0]        Regwdata;

  int checks = 0;
  int passed = 0;

  // reference model state
  bit          mbusy [32];
  bit          mwf;
  logic [4:0]  mwadd;
  logic [31:0] mwdata;
  int          mptr;

  wb_port_scheduler #(.NREQ(NREQ), .REG_AW(AW), .REG_DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_busy  (rsv_busy),
    .rd1_addr  (rd1_addr),
    .rd2_addr  (rd2_addr),
    .rd1_busy  (rd1_busy),
    .rd2_busy  (rd2_busy),
    .Regwf     (Regwf),
    .Regwadd   (Regwadd),
    .Regwdata  (Regwdata)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rd1_addr  = '0;
    rd2_addr  = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  function automatic int model_grant();
    int i;
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = RR ? (mptr + k) % NREQ : k;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    logic [4:0] a;
    if (rst) begin
      foreach (mbusy[j]) mbusy[j] = 1'b0;
      mwf = 1'b0; mwadd = '0; mwdata = '0; mptr = 0;
      return;
    end
    if (mwf) mbusy[mwadd] = 1'b0;
    if (rsv_valid && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
    if (g >= 0) begin
      a      = req_addr[g*AW +: AW];
      mwf    = (a != 0);
      mwadd  = a;
      mwdata = req_data[g*DW +: DW];
      mptr   = (g + 1) % NREQ;
    end else begin
      mwf = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 3), 32'hA000_0000 + i);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (Regwf !== 1'b0) $display("FAIL reset_regwf: got %b want 0", Regwf);
      else passed++;
    end
    rst = 1'b0;
    clear_inputs();
    checks++;
    if (Regwadd !== 5'd0 || Regwdata !== 32'd0)
      $display("FAIL reset_wregs: got %h/%h want 00/00000000", Regwadd, Regwdata);
    else passed++;
    for (int a = 0; a < 32; a++) begin
      rd1_addr = 5'(a);
      #1;
      checks++;
      if (rd1_busy !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", a, rd1_busy);
      else passed++;
    end
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 3'b010;
    set_req(1, 5'd8, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b010) $display("FAIL single_ready: got %b want 010", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (Regwf !== 1'b1 || Regwadd !== 5'd8 || Regwdata !== 32'hDEADBEEF)
      $display("FAIL single_write: got %b/%h/%h want 1/08/deadbeef", Regwf, Regwadd, Regwdata);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (Regwf !== 1'b0) $display("FAIL single_drop: got %b want 0", Regwf);
    else passed++;
  endtask

  task automatic test_arbitration;
    int e;
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(10 + i), 32'h100 + i);
    for (int c = 0; c < 6; c++) begin
      e = RR ? c % NREQ : 0;
      #1;
      checks++;
      if (req_ready !== 3'(1 << e)) $display("FAIL arb_grant[%0d]: got %b want %b", c, req_ready, 3'(1 << e));
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (Regwf !== 1'b1 || Regwadd !== 5'(10 + e))
        $display("FAIL arb_write[%0d]: got %b/%0d want 1/%0d", c, Regwf, Regwadd, 10 + e);
      else passed++;
    end
    req_valid = '0;
  endtask

  task automatic test_addr_zero;
    do_reset();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h1234);
    rd1_addr = 5'd5;
    #1;
    checks++;
    if (req_ready !== 3'b001) $display("FAIL zero_ready: got %b want 001", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (Regwf !== 1'b0) $display("FAIL zero_regwf: got %b want 0", Regwf);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (rd1_busy !== 1'b1 || rd2_busy !== 1'b0)
      $display("FAIL zero_busy: got %b%b want 10", rd1_busy, rd2_busy);
    else passed++;
  endtask

  task automatic test_scoreboard;
    do_reset();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    rd1_addr  = 5'd5;
    #1;
    checks++;
    if (rd1_busy !== 1'b0) $display("FAIL sb_pre: got %b want 0", rd1_busy);
    else passed++;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    checks++;
    if (rd1_busy !== 1'b1) $display("FAIL sb_set: got %b want 1", rd1_busy);
    else passed++;
    req_valid = 3'b100;
    set_req(2, 5'd5, 32'h5555_0005);
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (Regwf !== 1'b1 || rd1_busy !== 1'b1)
      $display("FAIL sb_wb_cycle: got wf=%b busy=%b want 1/1", Regwf, rd1_busy);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (Regwf !== 1'b0 || rd1_busy !== 1'b0)
      $display("FAIL sb_cleared: got wf=%b busy=%b want 0/0", Regwf, rd1_busy);
    else passed++;
    req_valid = 3'b001;
    set_req(0, 5'd5, 32'h0000_0055);
    @(posedge clk); #1;
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    rd2_addr  = 5'd5;
    #1;
    checks++;
    if (rd1_busy !== 1'b1 || rd2_busy !== 1'b1 || rsv_busy !== 1'b1)
      $display("FAIL sb_set_wins: got %b%b%b want 111", rd1_busy, rd2_busy, rsv_busy);
    else passed++;
    rsv_addr = 5'd0;
    #1;
    checks++;
    if (rsv_busy !== 1'b0) $display("FAIL sb_rsv_zero: got %b want 0", rsv_busy);
    else passed++;
  endtask

  task automatic test_reset_inflight;
    do_reset();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    req_valid = 3'b001;
    set_req(0, 5'd9, 32'h9999);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b000) $display("FAIL rstfl_ready: got %b want 000", req_ready);
    else passed++;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
    rd1_addr  = 5'd5;
    #1;
    checks++;
    if (Regwf !== 1'b0 || rd1_busy !== 1'b0)
      $display("FAIL rstfl_state: got wf=%b busy=%b want 0/0", Regwf, rd1_busy);
    else passed++;
  endtask

  task automatic test_random;
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [4:0] a;
    do_reset();
    foreach (mbusy[j]) mbusy[j] = 1'b0;
    mwf = 1'b0; mwadd = '0; mwdata = '0; mptr = 0;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      a         = 5'($urandom);
      rsv_addr  = a;
      rsv_valid = ($urandom_range(0, 2) == 0) && !mbusy[a];
      rd1_addr  = 5'($urandom);
      rd2_addr  = 5'($urandom);
      #1;
      g       = model_grant();
      exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
      checks++;
      if (req_ready !== exp_rdy) $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_rdy);
      else passed++;
      checks++;
      if (rd1_busy !== (rd1_addr != 0 && mbusy[rd1_addr]) ||
          rd2_busy !== (rd2_addr != 0 && mbusy[rd2_addr]) ||
          rsv_busy !== (rsv_addr != 0 && mbusy[rsv_addr]))
        $display("FAIL rnd_busy[%0d]: got %b%b%b want %b%b%b", c, rd1_busy, rd2_busy, rsv_busy,
                 rd1_addr != 0 && mbusy[rd1_addr], rd2_addr != 0 && mbusy[rd2_addr],
                 rsv_addr != 0 && mbusy[rsv_addr]);
      else passed++;
      @(posedge clk);
      model_edge(g);
      #1;
      checks++;
      if (Regwf !== mwf || (mwf && (Regwadd !== mwadd || Regwdata !== mwdata)))
        $display("FAIL rnd_write[%0d]: got %b/%h/%h want %b/%h/%h", c, Regwf, Regwadd, Regwdata,
                 mwf, mwadd, mwdata);
      else passed++;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_addr_zero();
    test_scoreboard();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
